// File: rtl/ram_pkg.sv
// Shared definitions for the wait-state data RAM: access-size codes, FSM
// encoding, latched request payload and an index-width helper.
package ram_pkg;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;
  localparam logic [1:0] HB_ILL  = 2'b11;

  // Wait-state counter width (0..15 wait states).
  localparam int unsigned WS_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request attributes captured in the grant cycle.
  typedef struct packed {
    logic        we;
    logic [1:0]  hb;
    logic        uload;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  // Ceiling log2 for the word-index width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_load_align.sv
// Load data alignment: selects the byte/half lane addressed by off_i from a
// 32-bit array word and sign- or zero-extends it to 32 bits.
//   word_i   array word as read
//   off_i    byte offset (addr[1:0]) of the access
//   hb_i     access size code
//   uload_i  1 = zero-extend, 0 = sign-extend (ignored for words)
//   data_o   aligned, extended load data (combinational)
module ram_load_align
  import ram_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  hb_i,
  input  logic        uload_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    case (hb_i)
      HB_BYTE: data_o = {{24{~uload_i & byte_sel[7]}}, byte_sel};
      HB_HALF: data_o = {{16{~uload_i & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/ram_wait_ctrl.sv
// Data-memory slave for the LSU port with programmable wait states, one
// outstanding transaction, sign/zero-extended loads and a bus-error response.
//   clk_i, rst_i      clock, synchronous active-high reset
//   ce_i, req_i       chip enable and request; gnt_o accepts (combinational)
//   we_i, hb_i,       store flag, size, zero-extend flag,
//   uload_i, addr_i,  byte address and LSB-justified store data,
//   wdata_i           sampled only in the grant cycle
//   rvalid_o, err_o,  one-cycle response strobe with error flag and
//   rdata_o           load data (zero unless a successful load responds)
module ram_wait_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] INIT_WORD   = 32'h0000_00EF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ce_i,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic        err_o,
  input  logic        we_i,
  input  logic [1:0]  hb_i,
  input  logic        uload_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);

  localparam int unsigned AW = clog2(DEPTH_WORDS);
  localparam int unsigned CW = WS_W;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           grant;
  req_t           req_q;
  logic [AW-1:0]  idx_q;
  logic           err_q;

  logic           err_in;
  logic [AW-1:0]  idx_in;
  logic [AW-1:0]  rd_idx;
  logic [31:0]    rd_word_q;
  logic [31:0]    load_data;
  logic [3:0]     be;
  logic [31:0]    wr_lanes;
  logic           wr_en;
  logic           resp_live;

  // The array holds data XOR INIT_WORD, so a zero-initialised array reads
  // back as INIT_WORD everywhere without any load-time initialisation.
  logic [31:0]    mem_q [DEPTH_WORDS];

  // Error decode on the live request; BASE_ADDR is aligned to the array
  // size, so the range check reduces to comparing the upper address bits.
  always_comb begin
    err_in = 1'b0;
    case (hb_i)
      HB_HALF: err_in = addr_i[0];
      HB_WORD: err_in = |addr_i[1:0];
      HB_ILL:  err_in = 1'b1;
      default: err_in = 1'b0;
    endcase
    if (addr_i[31:AW+2] != BASE_ADDR[31:AW+2]) err_in = 1'b1;
  end

  // Same alignment argument: (addr - BASE_ADDR) >> 2 is just the index bits.
  assign idx_in = addr_i[AW+1:2];

  // Next-state, counter and grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        grant = req_i & ce_i & ~rst_i;
        if (grant) begin
          cnt_d = CW'(WAIT_STATES);
          if (WAIT_STATES > 0) state_d = WAIT;
          else                 state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and request capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        req_q <= '{we: we_i, hb: hb_i, uload: uload_i, off: addr_i[1:0], wdata: wdata_i};
        idx_q <= idx_in;
        err_q <= err_in;
      end
    end
  end

  // With zero wait states RESP is entered at the grant edge, before idx_q
  // is loaded, so the read index comes straight from the address then.
  assign rd_idx = (state_q == IDLE) ? idx_in : idx_q;

  // Synchronous array read on the edge entering RESP.
  always_ff @(posedge clk_i) begin
    if (state_d == RESP) rd_word_q <= mem_q[rd_idx] ^ INIT_WORD;
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be       = 4'b0000;
    wr_lanes = req_q.wdata;
    case (req_q.hb)
      HB_BYTE: begin
        be       = 4'b0001 << req_q.off;
        wr_lanes = {4{req_q.wdata[7:0]}};
      end
      HB_HALF: begin
        be       = req_q.off[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{req_q.wdata[15:0]}};
      end
      HB_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Store commits on the edge leaving RESP unless errored or reset.
  assign wr_en = (state_q == RESP) & req_q.we & ~err_q & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx_q][8*i +: 8] <= wr_lanes[8*i +: 8] ^ INIT_WORD[8*i +: 8];
      end
    end
  end

  ram_load_align u_align (
    .word_i  (rd_word_q),
    .off_i   (req_q.off),
    .hb_i    (req_q.hb),
    .uload_i (req_q.uload),
    .data_o  (load_data)
  );

  // A reset during RESP suppresses the response, since its store is dropped.
  assign resp_live = (state_q == RESP) & ~rst_i;

  assign gnt_o    = grant;
  assign rvalid_o = resp_live;
  assign err_o    = resp_live & err_q;
  // Stores and errored accesses respond with zero data.
  assign rdata_o  = (resp_live & ~err_q & ~req_q.we) ? load_data : 32'h0;

endmodule
